// File: rtl/cache_arb_pkg.sv
// Shared types for the L1-to-lower-level line port arbiter.
// Imported by the interface, the picker and the arbiter top.
package cache_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } arb_state_t;

   typedef enum logic {
      SIDE_I,
      SIDE_D
   } side_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } op_t;

   function automatic side_t other_side(input side_t s);
      return (s == SIDE_I) ? SIDE_D : SIDE_I;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of I-cache, D-cache and lower line port signals.
// slave is the arbiter view, master the surrounding caches/memory.
interface cache_mem_arbiter_if
   import cache_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
);

   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              l_read;
   logic              l_write;
   logic [ADDR_W-1:0] l_addr;
   logic [LINE_W-1:0] l_wdata;
   logic [LINE_W-1:0] l_rdata;
   logic              l_resp;

   modport slave (
      input  i_read, i_addr,
      output i_rdata, i_resp,
      input  d_read, d_write, d_addr, d_wdata,
      output d_rdata, d_resp,
      output l_read, l_write, l_addr, l_wdata,
      input  l_rdata, l_resp
   );

   modport master (
      output i_read, i_addr,
      input  i_rdata, i_resp,
      output d_read, d_write, d_addr, d_wdata,
      input  d_rdata, d_resp,
      input  l_read, l_write, l_addr, l_wdata,
      output l_rdata, l_resp
   );

endinterface

// File: rtl/rr_picker2.sv
// Two-way round-robin pick: a lone request wins,
// a tie goes to the side that was not granted last.
module rr_picker2
   import cache_arb_pkg::*;
(
   input  logic [1:0] req,
   input  side_t      last,
   output logic       gnt_valid,
   output side_t      gnt_side
);

   always_comb begin
      gnt_valid = |req;
      gnt_side  = SIDE_I;
      unique case (1'b1)
         (req[1] & req[0]):  gnt_side = other_side(last);
         (req[1] & ~req[0]): gnt_side = SIDE_D;
         (~req[1]):          gnt_side = SIDE_I;
         default:            gnt_side = SIDE_I;
      endcase
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one lower line port between I-cache and D-cache,
// one latched transaction at a time, round-robin granted.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
)(
   input  logic clk,
   input  logic rst_n,
   cache_mem_arbiter_if.slave bus
);

   arb_state_t        state;
   side_t             last_grant;
   op_t               lat_op;
   logic [ADDR_W-1:0] lat_addr;
   logic [LINE_W-1:0] lat_wdata;
   logic              l_read_q;
   logic              l_write_q;

   logic       d_pend;
   logic [1:0] pend;
   logic [1:0] pick_req;
   logic       gnt_valid;
   side_t      gnt_side;
   op_t        gnt_op;
   logic       req_active;
   logic       done;
   logic       take;
   logic       issue_now;
   logic       reissue;

   assign d_pend     = bus.d_read | bus.d_write;
   assign pend       = {d_pend, bus.i_read};
   assign req_active = l_read_q | l_write_q;
   assign done       = bus.l_resp & req_active
                     & (state != IDLE);

   // At handover only the other side may win.
   always_comb begin
      pick_req = 2'b00;
      unique case (state)
         IDLE:    pick_req = pend;
         SERVE_I: pick_req = {pend[1], 1'b0};
         SERVE_D: pick_req = {1'b0, pend[0]};
         default: pick_req = 2'b00;
      endcase
   end

   rr_picker2 u_pick (
      .req       (pick_req),
      .last      (last_grant),
      .gnt_valid (gnt_valid),
      .gnt_side  (gnt_side)
   );

   assign gnt_op = (gnt_side == SIDE_D && bus.d_write)
                 ? OP_WRITE : OP_READ;

   assign take      = gnt_valid & ((state == IDLE) | done);
   assign issue_now = take & (state == IDLE);
   assign reissue   = (state != IDLE) & ~req_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= SIDE_I;
         lat_op     <= OP_READ;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         l_read_q   <= 1'b0;
         l_write_q  <= 1'b0;
      end else begin
         if (take) begin
            state <= (gnt_side == SIDE_D)
                   ? SERVE_D : SERVE_I;
            last_grant <= gnt_side;
            lat_op     <= gnt_op;
            lat_addr   <= (gnt_side == SIDE_D)
                        ? bus.d_addr : bus.i_addr;
            if (gnt_side == SIDE_D)
               lat_wdata <= bus.d_wdata;
         end else if (done) begin
            state <= IDLE;
         end
         // A handover leaves one idle cycle before re-issuing.
         unique case (1'b1)
            issue_now: begin
               l_read_q  <= (gnt_op == OP_READ);
               l_write_q <= (gnt_op == OP_WRITE);
            end
            done: begin
               l_read_q  <= 1'b0;
               l_write_q <= 1'b0;
            end
            reissue: begin
               l_read_q  <= (lat_op == OP_READ);
               l_write_q <= (lat_op == OP_WRITE);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.l_read  = l_read_q;
   assign bus.l_write = l_write_q;
   assign bus.l_addr  = lat_addr;
   assign bus.l_wdata = lat_wdata;
   assign bus.i_rdata = bus.l_rdata;
   assign bus.d_rdata = bus.l_rdata;
   assign bus.i_resp  = done & (state == SERVE_I);
   assign bus.d_resp  = done & (state == SERVE_D);

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         if (state == SERVE_I)
            assert (bus.i_read)
            else $error("i_read dropped before i_resp");
         if (state == SERVE_D)
            assert (d_pend)
            else $error("d request dropped before d_resp");
         assert (!(bus.d_read && bus.d_write))
         else $warning("d_read and d_write both set");
         if (!(state inside {IDLE, SERVE_I, SERVE_D}))
            $fatal(1, "arbiter in illegal state %0d", state);
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and random bench for cache_mem_arbiter against
// a transaction-level round-robin model.
module tb_cache_mem_arbiter;
   import cache_arb_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n;
   int    checks = 0;
   int    failures = 0;
   side_t last_srv;

   always #5 clk = ~clk;

   cache_mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

   cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag,
                      input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic side_t tie_winner();
      return (last_srv == SIDE_I) ? SIDE_D : SIDE_I;
   endfunction

   task automatic req(input side_t s, input logic [31:0] a,
                      input bit wr, input logic [255:0] wd);
      if (s == SIDE_I) begin
         bus.i_addr = a;
         bus.i_read = 1'b1;
      end else begin
         bus.d_addr  = a;
         bus.d_wdata = wd;
         bus.d_write = wr;
         bus.d_read  = !wr;
      end
   endtask

   task automatic drop(input side_t s);
      if (s == SIDE_I) bus.i_read = 1'b0;
      else begin
         bus.d_read  = 1'b0;
         bus.d_write = 1'b0;
      end
   endtask

   // Acts as the lower memory for one transaction of side s.
   task automatic serve(input side_t s, input logic [31:0] a,
                        input bit wr, input logic [255:0] wd,
                        input int lat, input bit dropit,
                        input bit scramble);
      int n;
      logic [255:0] rd;
      n = 0;
      #3;
      while (!(bus.l_read | bus.l_write) && n < 10) begin
         @(posedge clk);
         #4;
         n++;
      end
      chk("req_latency", 256'(n), 256'(1));
      if (n >= 10) begin
         drop(s);
         tick();
         return;
      end
      chk("l_read", 256'(bus.l_read), 256'(!wr));
      chk("l_write", 256'(bus.l_write), 256'(wr));
      chk("l_addr", 256'(bus.l_addr), 256'(a));
      if (wr) chk("l_wdata", bus.l_wdata, wd);
      if (scramble) begin
         bus.d_addr  = $urandom;
         bus.d_wdata = rnd_line();
      end
      repeat (lat) begin
         @(posedge clk);
         #4;
         chk("hold",
             256'({bus.l_read, bus.l_write, bus.i_resp,
                   bus.d_resp, bus.l_addr}),
             256'({!wr, wr, 2'b00, a}));
         if (wr) chk("hold_wdata", bus.l_wdata, wd);
      end
      rd = rnd_line();
      bus.l_rdata = rd;
      bus.l_resp = 1'b1;
      #1;
      chk("i_resp", 256'(bus.i_resp), 256'(s == SIDE_I));
      chk("d_resp", 256'(bus.d_resp), 256'(s == SIDE_D));
      chk("rdata", (s == SIDE_I) ? bus.i_rdata : bus.d_rdata, rd);
      @(posedge clk);
      #1;
      bus.l_resp = 1'b0;
      if (dropit) drop(s);
      last_srv = s;
   endtask

   initial begin
      logic [31:0]  ia, da;
      logic [255:0] dwd, rl;
      bit           dwr;
      side_t        s, f;
      int           n, mode;

      bus.i_read = 0; bus.i_addr = 0;
      bus.d_read = 0; bus.d_write = 0;
      bus.d_addr = 0; bus.d_wdata = 0;
      bus.l_rdata = 0; bus.l_resp = 0;
      rst_n = 1'b0;
      last_srv = SIDE_I;
      #2;
      chk("rst_outs",
          256'({bus.l_read, bus.l_write, bus.i_resp, bus.d_resp}),
          256'(0));
      chk("rst_addr", 256'(bus.l_addr), 256'(0));
      chk("rst_wdata", bus.l_wdata, 256'(0));
      rl = rnd_line();
      bus.l_rdata = rl;
      #1;
      chk("rst_i_rdata", bus.i_rdata, rl);
      chk("rst_d_rdata", bus.d_rdata, rl);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // I-only read
      req(SIDE_I, 32'h100, 0, '0);
      serve(SIDE_I, 32'h100, 0, '0, 3, 1, 0);
      tick();

      // simultaneous reads: D first after reset
      req(SIDE_I, 32'h140, 0, '0);
      req(SIDE_D, 32'h180, 0, '0);
      f = tie_winner();
      chk("tie_is_d", 256'(f), 256'(SIDE_D));
      serve(f, (f == SIDE_D) ? 32'h180 : 32'h140, 0, '0, 1, 1, 0);
      f = other_side(f);
      serve(f, (f == SIDE_D) ? 32'h180 : 32'h140, 0, '0, 2, 1, 0);
      tick();

      // write with address changed after grant
      dwd = {8{32'hDEADBEEF}};
      req(SIDE_D, 32'h2A0, 1, dwd);
      serve(SIDE_D, 32'h2A0, 1, dwd, 4, 1, 1);
      tick();

      // read and write together behaves as a write
      dwd = rnd_line();
      req(SIDE_D, 32'h3C0, 1, dwd);
      bus.d_read = 1'b1;
      serve(SIDE_D, 32'h3C0, 1, dwd, 1, 1, 0);
      tick();

      // both held for six transactions: strict alternation
      ia = 32'h1000; da = 32'h2000; dwd = rnd_line();
      req(SIDE_I, ia, 0, '0);
      req(SIDE_D, da, 1, dwd);
      for (int t = 0; t < 6; t++) begin
         s = (t == 0) ? tie_winner() : other_side(last_srv);
         serve(s, (s == SIDE_D) ? da : ia, s == SIDE_D, dwd,
               $urandom_range(0, 3), t >= 4, 0);
      end
      tick();

      // reset in the middle of a D write
      dwd = rnd_line();
      req(SIDE_D, 32'h4E0, 1, dwd);
      n = 0;
      #3;
      while (!bus.l_write && n < 10) begin
         @(posedge clk);
         #4;
         n++;
      end
      chk("pre_rst_write", 256'(bus.l_write), 256'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_drop",
          256'({bus.l_read, bus.l_write, bus.d_resp, bus.i_resp}),
          256'(0));
      drop(SIDE_D);
      last_srv = SIDE_I;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      #3;
      chk("post_rst_idle",
          256'({bus.l_read, bus.l_write}), 256'(0));
      tick();
      req(SIDE_D, 32'h4E0, 1, dwd);
      serve(SIDE_D, 32'h4E0, 1, dwd, 2, 1, 0);
      tick();

      // spurious l_resp while idle
      bus.l_resp = 1'b1;
      #3;
      chk("spur_resp",
          256'({bus.i_resp, bus.d_resp}), 256'(0));
      @(posedge clk);
      #1 bus.l_resp = 1'b0;
      #3;
      chk("spur_idle",
          256'({bus.l_read, bus.l_write}), 256'(0));
      tick();
      req(SIDE_I, 32'h500, 0, '0);
      serve(SIDE_I, 32'h500, 0, '0, 0, 1, 0);
      tick();

      // random rounds
      for (int r = 0; r < 24; r++) begin
         mode = $urandom_range(1, 3);
         ia  = $urandom;
         da  = $urandom;
         dwr = 1'($urandom_range(0, 1));
         dwd = rnd_line();
         if (mode[0]) req(SIDE_I, ia, 0, '0);
         if (mode[1]) req(SIDE_D, da, dwr, dwd);
         if (mode == 3) begin
            f = tie_winner();
            serve(f, (f == SIDE_D) ? da : ia,
                  (f == SIDE_D) && dwr, dwd,
                  $urandom_range(0, 4), 1, 0);
            f = other_side(f);
            serve(f, (f == SIDE_D) ? da : ia,
                  (f == SIDE_D) && dwr, dwd,
                  $urandom_range(0, 4), 1, 0);
         end else if (mode == 1) begin
            serve(SIDE_I, ia, 0, '0,
                  $urandom_range(0, 4), 1, 0);
         end else begin
            serve(SIDE_D, da, dwr, dwd,
                  $urandom_range(0, 4), 1, 0);
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
